ps2_kbc: RTL and testbench

Parametrised two-channel 8042-style keyboard/mouse controller bridging the RISC-V housekeeping core to the 286 I/O space. The RISC-V pushes keyboard and auxiliary (mouse) scancodes into two FIFOs. The x86 CPU reads them through ports 060h and 064h, receiving IRQ1 or IRQ12. Bytes the CPU writes to 060h/064h are latched for the RISC-V to forward to the devices.

---
 rtl/ps2_kbc_if.sv | 21 ++
 rtl/ps2_kbc.sv | 246 ++++++++++++++++++++++++
 tb/tb_ps2_kbc.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_kbc_if.sv
// ps2_kbc_if: RISC-V side register bus of the
// 8042-style keyboard/aux controller.
interface ps2_kbc_if;
  logic [9:0]  r_addr;
  logic [31:0] r_din;
  logic [31:0] r_dout;
  logic [3:0]  r_lane;
  logic        r_wr;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output r_addr, r_din, r_lane, r_wr, r_valid,
    input  r_dout, r_ready
  );

  modport slave (
    input  r_addr, r_din, r_lane, r_wr, r_valid,
    output r_dout, r_ready
  );
endinterface

// File: rtl/ps2_kbc.sv
// ps2_kbc: two-channel 8042-style controller; RISC-V
// pushes scancodes, the x86 reads them at 060h/064h.
module ps2_kbc #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AUX_EN     = 1,
  parameter int ACK_MODE   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  ps2_kbc_if.slave    rbus,
  input  logic [11:0] port,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        cpu_iordin,
  input  logic        cpu_iowrin,
  output logic        cpu_iordout,
  output logic        cpu_iowrout,
  output logic        irq1,
  output logic        irq12
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {
    P_IDLE,
    P_KBD,
    P_AUX
  } pres_e;

  logic        iord;
  logic        iowr;
  logic        sel60;
  logic        sel61;
  logic        sel64;
  logic        acc;
  logic        r_ready_q;
  logic [31:0] r_dout_q;
  logic [31:0] rd_data;
  logic [31:0] status;
  logic [1:0]  rsel;
  logic        push_k;
  logic        push_a;
  logic        st_wr;
  logic        cmd_rd;
  logic        cmd_wr;
  logic [1:0]  push;
  logic [1:0]  pop;
  cnt_t        cnt_k;
  cnt_t        cnt_a;
  logic [7:0]  head_k;
  logic [7:0]  head_a;
  logic [7:0]  head_cur;
  logic        full_k;
  logic        full_a;
  logic        kovf;
  logic        aovf;
  logic [7:0]  cmd_byte;
  logic        cmd_via;
  logic        cmd_pend;
  logic        cmd_ovr;
  pres_e       state;
  pres_e       state_nx;
  logic        pres_valid;
  logic        cur_ch;
  logic        pop_req;
  logic        do_pop;
  logic        unused_ok;

  assign iord = cpu_iordout ^ cpu_iordin;
  assign iowr = cpu_iowrout ^ cpu_iowrin;

  // port decode settles on the falling edge
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel60 <= 1'b0;
      sel61 <= 1'b0;
      sel64 <= 1'b0;
    end else begin
      sel60 <= (port == 12'h060);
      sel61 <= (port == 12'h061);
      sel64 <= (port == 12'h064);
    end
  end

  assign rsel   = rbus.r_addr[3:2];
  assign acc    = rbus.r_valid & ~r_ready_q;
  assign push_k = acc & rbus.r_wr & (rsel == 2'd0)
                & rbus.r_lane[0];
  assign push_a = acc & rbus.r_wr & (rsel == 2'd1)
                & rbus.r_lane[0] & (AUX_EN != 0);
  assign st_wr  = acc & rbus.r_wr & (rsel == 2'd2);
  assign cmd_rd = acc & ~rbus.r_wr & (rsel == 2'd3);
  assign cmd_wr = iowr & (sel60 | sel64);
  assign push   = {push_a, push_k};

  for (genvar c = 0; c < 2; c++) begin : g_fifo
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    cnt_t                  cnt;
    logic                  wr_en;
    logic [7:0]            hd;

    assign wr_en = push[c] & (cnt != cnt_t'(DEPTH));
    assign hd    = mem[rp];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (wr_en) wp <= wp + 1'b1;
        if (pop[c]) rp <= rp + 1'b1;
        if (wr_en && !pop[c]) cnt <= cnt + 1'b1;
        else if (!wr_en && pop[c]) cnt <= cnt - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[wp] <= rbus.r_din[7:0];
    end
  end

  assign cnt_k  = g_fifo[0].cnt;
  assign cnt_a  = g_fifo[1].cnt;
  assign head_k = g_fifo[0].hd;
  assign head_a = g_fifo[1].hd;
  assign full_k = (cnt_k == cnt_t'(DEPTH));
  assign full_a = (cnt_a == cnt_t'(DEPTH));

  assign pres_valid = (state != P_IDLE);
  assign cur_ch     = (state == P_AUX);
  assign head_cur   = cur_ch ? head_a : head_k;
  assign pop_req    = (ACK_MODE != 0) ? (iord & sel60)
                                      : (iowr & sel61);
  assign do_pop     = pop_req & pres_valid;
  assign pop        = {do_pop & cur_ch, do_pop & ~cur_ch};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= P_IDLE;
    else          state <= state_nx;
  end

  // keyboard wins when both channels hold data
  always_comb begin
    state_nx = state;
    unique case (state)
      P_IDLE: begin
        if (cnt_k != '0)      state_nx = P_KBD;
        else if (cnt_a != '0) state_nx = P_AUX;
      end
      default: begin
        if (do_pop) state_nx = P_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kovf <= 1'b0;
      aovf <= 1'b0;
    end else begin
      if (st_wr && rbus.r_din[16]) kovf <= 1'b0;
      if (st_wr && rbus.r_din[17]) aovf <= 1'b0;
      if (push_k && full_k) kovf <= 1'b1;
      if (push_a && full_a) aovf <= 1'b1;
    end
  end

  // a CPU write racing a RISC-V read keeps pending set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_byte <= '0;
      cmd_via  <= 1'b0;
      cmd_pend <= 1'b0;
      cmd_ovr  <= 1'b0;
    end else begin
      if (st_wr && rbus.r_din[25]) cmd_ovr <= 1'b0;
      if (cmd_wr) begin
        cmd_byte <= din;
        cmd_via  <= sel64;
        cmd_pend <= 1'b1;
        if (cmd_pend && !cmd_rd) cmd_ovr <= 1'b1;
      end else if (cmd_rd) begin
        cmd_pend <= 1'b0;
      end
    end
  end

  always_comb begin
    status                 = '0;
    status[DEPTH_LOG2:0]   = cnt_k;
    status[8 +: CW]        = cnt_a;
    status[16]             = kovf;
    status[17]             = aovf;
    status[24]             = cmd_pend;
    status[25]             = cmd_ovr;
  end

  always_comb begin
    rd_data = '0;
    if (!rbus.r_wr) begin
      case (rsel)
        2'd2:    rd_data = status;
        2'd3:    rd_data = {cmd_pend, 22'd0,
                            cmd_via, cmd_byte};
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_iordout <= 1'b0;
      cpu_iowrout <= 1'b0;
      r_ready_q   <= 1'b0;
      r_dout_q    <= '0;
      dout        <= '0;
      irq1        <= 1'b0;
      irq12       <= 1'b0;
    end else begin
      cpu_iordout <= cpu_iordin;
      cpu_iowrout <= cpu_iowrin;
      r_ready_q   <= acc;
      if (acc) r_dout_q <= rd_data;
      if (iord && sel64)
        dout <= {2'b00, pres_valid & cur_ch, 3'b000,
                 cmd_pend, pres_valid};
      else if (pres_valid)
        dout <= head_cur;
      irq1  <= pres_valid & ~cur_ch;
      irq12 <= (AUX_EN != 0) & pres_valid & cur_ch;
    end
  end

  assign rbus.r_ready = r_ready_q;
  assign rbus.r_dout  = r_dout_q;

  assign unused_ok = ^{rbus.r_addr[9:4], rbus.r_addr[1:0],
                       rbus.r_din[31:26], rbus.r_din[24:18],
                       rbus.r_din[15:8], rbus.r_lane[3:1]};

endmodule

// File: tb/tb_ps2_kbc.sv
// tb_ps2_kbc: two instances (ACK on 061h with aux, ACK on
// 060h read without aux) checked against a queue model.
module tb_ps2_kbc;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][9:0]  ra;
  logic [1:0][31:0] rdi;
  logic [1:0][3:0]  rl;
  logic [1:0]       rw;
  logic [1:0]       rv;
  logic [1:0][31:0] rdo;
  logic [1:0]       rr;
  logic [1:0][11:0] prt;
  logic [1:0][7:0]  di;
  logic [1:0][7:0]  dq;
  logic [1:0]       iri;
  logic [1:0]       iwi;
  logic [1:0]       iro;
  logic [1:0]       iwo;
  logic [1:0]       i1;
  logic [1:0]       i12;

  ps2_kbc_if b0 ();
  ps2_kbc_if b1 ();

  assign b0.r_addr  = ra[0];
  assign b0.r_din   = rdi[0];
  assign b0.r_lane  = rl[0];
  assign b0.r_wr    = rw[0];
  assign b0.r_valid = rv[0];
  assign rdo[0]     = b0.r_dout;
  assign rr[0]      = b0.r_ready;
  assign b1.r_addr  = ra[1];
  assign b1.r_din   = rdi[1];
  assign b1.r_lane  = rl[1];
  assign b1.r_wr    = rw[1];
  assign b1.r_valid = rv[1];
  assign rdo[1]     = b1.r_dout;
  assign rr[1]      = b1.r_ready;

  ps2_kbc #(.DEPTH_LOG2(4), .AUX_EN(1), .ACK_MODE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .rbus(b0.slave),
    .port(prt[0]), .din(di[0]), .dout(dq[0]),
    .cpu_iordin(iri[0]), .cpu_iowrin(iwi[0]),
    .cpu_iordout(iro[0]), .cpu_iowrout(iwo[0]),
    .irq1(i1[0]), .irq12(i12[0])
  );

  ps2_kbc #(.DEPTH_LOG2(4), .AUX_EN(0), .ACK_MODE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .rbus(b1.slave),
    .port(prt[1]), .din(di[1]), .dout(dq[1]),
    .cpu_iordin(iri[1]), .cpu_iowrin(iwi[1]),
    .cpu_iordout(iro[1]), .cpu_iowrout(iwo[1]),
    .irq1(i1[1]), .irq12(i12[1])
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string nm, int d,
                     logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h, expected %h",
               nm, d, act, exp);
    end
  endtask

  function automatic bit auxen(int d);
    return d == 0;
  endfunction

  function automatic bit ackm(int d);
    return d == 1;
  endfunction

  // model: queues 2d (kbd) and 2d+1 (aux)
  logic [7:0]  mq [4][$];
  bit          m_pres [2];
  bit          m_ch   [2];
  bit          m_rr   [2];
  logic [31:0] m_rdo  [2];
  logic [7:0]  m_dout [2];
  bit          m_i1   [2];
  bit          m_i12  [2];
  bit          m_kovf [2];
  bit          m_aovf [2];
  logic [7:0]  m_cb   [2];
  bit          m_cv   [2];
  bit          m_cp   [2];
  bit          m_co   [2];
  bit          m_rtog [2];
  bit          m_wtog [2];

  function automatic logic [31:0] mstatus(int d);
    logic [31:0] s;
    s = 32'(mq[2*d].size()) + (32'(mq[2*d+1].size()) << 8);
    if (m_kovf[d]) s = s + 32'h0001_0000;
    if (m_aovf[d]) s = s + 32'h0002_0000;
    if (m_cp[d])   s = s + 32'h0100_0000;
    if (m_co[d])   s = s + 32'h0200_0000;
    return s;
  endfunction

  task automatic m_step(int d);
    bit iord, iowr, acc, p60, p61, p64, crd, cwr, popr;
    logic [1:0]  rg;
    logic [31:0] st;
    int k, a;
    k = 2 * d;
    a = 2 * d + 1;
    if (!reset_n) begin
      mq[k].delete(); mq[a].delete();
      m_pres[d] = 0; m_ch[d] = 0; m_rr[d] = 0;
      m_rdo[d] = '0; m_dout[d] = '0; m_i1[d] = 0;
      m_i12[d] = 0; m_kovf[d] = 0; m_aovf[d] = 0;
      m_cb[d] = '0; m_cv[d] = 0; m_cp[d] = 0; m_co[d] = 0;
      m_rtog[d] = 0; m_wtog[d] = 0;
      return;
    end
    iord = (iri[d] != m_rtog[d]);
    iowr = (iwi[d] != m_wtog[d]);
    m_rtog[d] = iri[d];
    m_wtog[d] = iwi[d];
    p60 = (prt[d] == 12'h060);
    p61 = (prt[d] == 12'h061);
    p64 = (prt[d] == 12'h064);
    rg  = ra[d][3:2];
    acc = rv[d] && !m_rr[d];
    st  = mstatus(d);
    if (acc) begin
      if (rw[d])        m_rdo[d] = '0;
      else if (rg == 2) m_rdo[d] = st;
      else if (rg == 3) m_rdo[d] = {m_cp[d], 22'd0, m_cv[d], m_cb[d]};
      else              m_rdo[d] = '0;
    end
    m_rr[d] = acc;
    if (iord && p64)
      m_dout[d] = {2'b00, m_pres[d] && m_ch[d], 3'b000,
                   m_cp[d], m_pres[d]};
    else if (m_pres[d])
      m_dout[d] = mq[m_ch[d] ? a : k][0];
    m_i1[d]  = m_pres[d] && !m_ch[d];
    m_i12[d] = m_pres[d] && m_ch[d] && auxen(d);
    popr = ackm(d) ? (iord && p60) : (iowr && p61);
    if (m_pres[d]) begin
      if (popr) begin
        void'(mq[m_ch[d] ? a : k].pop_front());
        m_pres[d] = 0;
      end
    end else if (mq[k].size() > 0) begin
      m_pres[d] = 1; m_ch[d] = 0;
    end else if (mq[a].size() > 0) begin
      m_pres[d] = 1; m_ch[d] = 1;
    end
    crd = acc && !rw[d] && (rg == 3);
    cwr = iowr && (p60 || p64);
    if (acc && rw[d] && rg == 2) begin
      if (rdi[d][16]) m_kovf[d] = 0;
      if (rdi[d][17]) m_aovf[d] = 0;
      if (rdi[d][25]) m_co[d] = 0;
    end
    if (cwr) begin
      if (m_cp[d] && !crd) m_co[d] = 1;
      m_cb[d] = di[d]; m_cv[d] = p64; m_cp[d] = 1;
    end else if (crd) begin
      m_cp[d] = 0;
    end
    if (acc && rw[d] && rl[d][0]) begin
      if (rg == 0) begin
        if (mq[k].size() < DEPTH) mq[k].push_back(rdi[d][7:0]);
        else m_kovf[d] = 1;
      end else if (rg == 1 && auxen(d)) begin
        if (mq[a].size() < DEPTH) mq[a].push_back(rdi[d][7:0]);
        else m_aovf[d] = 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    m_step(0);
    m_step(1);
  end

  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      for (int d = 0; d < 2; d++) begin
        chk("irq1", d, i1[d], m_i1[d]);
        chk("irq12", d, i12[d], m_i12[d]);
        chk("r_ready", d, rr[d], m_rr[d]);
        if (m_rr[d]) chk("r_dout", d, rdo[d], m_rdo[d]);
        chk("dout", d, dq[d], m_dout[d]);
        chk("iordout", d, iro[d], m_rtog[d]);
        chk("iowrout", d, iwo[d], m_wtog[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rv_acc(int d, bit wr, logic [1:0] rg,
                        logic [31:0] wd, output logic [31:0] rd);
    int n;
    ra[d]  = {6'd0, rg, 2'd0};
    rdi[d] = wd;
    rw[d]  = wr;
    rl[d]  = 4'hF;
    rv[d]  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rr[d] && n < 8);
    if (!rr[d]) begin
      nchk++;
      nerr++;
      $display("FAIL rv_timeout dut%0d: r_ready=0 after %0d cycles, expected 1",
               d, n);
    end
    rd = rdo[d];
    rv[d] = 1'b0;
  endtask

  task automatic cpu_rd(int d, logic [11:0] a, output logic [7:0] v);
    prt[d] = a;
    iri[d] = ~iri[d];
    tick();
    v = dq[d];
  endtask

  task automatic cpu_wr(int d, logic [11:0] a, logic [7:0] v);
    prt[d] = a;
    di[d]  = v;
    iwi[d] = ~iwi[d];
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [7:0]  b;
    ra = '0; rdi = '0; rl = '0; rw = '0; rv = '0;
    prt = '0; di = '0; iri = '0; iwi = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_r_dout", d, rdo[d], 32'h0);
      chk("rst_dout", d, dq[d], 8'h00);
      chk("rst_irq", d, {i1[d], i12[d], rr[d]}, 3'b000);
    end

    // keyboard byte, irq latency, ack via 061h
    rv_acc(0, 1, 2'd0, 32'h1C, r);
    tick(); chk("irq1_lat2", 0, i1[0], 1'b0);
    tick(); chk("irq1_lat3", 0, i1[0], 1'b1);
    cpu_rd(0, 12'h060, b); chk("rd60", 0, b, 8'h1C);
    cpu_wr(0, 12'h061, 8'h00);
    tick(); chk("irq1_ack", 0, i1[0], 1'b0);
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_empty", 0, r, 32'h0);

    // aux pushed first is presented first
    rv_acc(0, 1, 2'd1, 32'h08, r);
    rv_acc(0, 1, 2'd0, 32'h1C, r);
    tick(); tick();
    chk("irq12_aux", 0, i12[0], 1'b1);
    chk("irq1_aux", 0, i1[0], 1'b0);
    cpu_rd(0, 12'h064, b); chk("st64_aux", 0, b, 8'h21);
    cpu_wr(0, 12'h061, 8'h00);
    tick(); tick();
    chk("irq1_next", 0, i1[0], 1'b1);
    chk("irq12_next", 0, i12[0], 1'b0);
    cpu_rd(0, 12'h060, b); chk("rd60_next", 0, b, 8'h1C);
    cpu_wr(0, 12'h061, 8'h00);

    // overflow: 17th byte dropped
    for (int i = 0; i < 17; i++) rv_acc(0, 1, 2'd0, 32'(i), r);
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_full", 0, r, 32'h0001_0010);
    for (int i = 0; i < 16; i++) begin
      cpu_rd(0, 12'h060, b); chk("pop_order", 0, b, 8'(i));
      cpu_wr(0, 12'h061, 8'h00);
      tick();
    end
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_drain", 0, r, 32'h0001_0000);
    rv_acc(0, 1, 2'd2, 32'h0001_0000, r);
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_w1c", 0, r, 32'h0);

    // push and pop on the same edge
    rv_acc(0, 1, 2'd0, 32'h5A, r);
    tick(); tick(); tick();
    ra[0] = 10'd0; rdi[0] = 32'hA5; rw[0] = 1'b1;
    rl[0] = 4'hF; rv[0] = 1'b1;
    prt[0] = 12'h061; iwi[0] = ~iwi[0];
    tick();
    rv[0] = 1'b0;
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_pushpop", 0, r, 32'h1);
    cpu_rd(0, 12'h060, b); chk("rd_pushpop", 0, b, 8'hA5);
    cpu_wr(0, 12'h061, 8'h00);

    // command byte overrun
    cpu_wr(0, 12'h060, 8'hED);
    cpu_wr(0, 12'h064, 8'h64);
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_ovr", 0, r, 32'h0300_0000);
    rv_acc(0, 0, 2'd3, 0, r); chk("cmd_rd1", 0, r, 32'h8000_0164);
    rv_acc(0, 0, 2'd3, 0, r); chk("cmd_rd2", 0, r, 32'h0000_0164);
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_ovr2", 0, r, 32'h0200_0000);
    rv_acc(0, 1, 2'd2, 32'h0200_0000, r);
    rv_acc(0, 0, 2'd2, 0, r); chk("stat_clr", 0, r, 32'h0);

    // ack on 060h read
    rv_acc(1, 1, 2'd0, 32'hA1, r);
    rv_acc(1, 1, 2'd0, 32'hB2, r);
    rv_acc(1, 1, 2'd0, 32'hC3, r);
    tick();
    cpu_rd(1, 12'h060, b); chk("ack1_a", 1, b, 8'hA1);
    tick();
    cpu_rd(1, 12'h060, b); chk("ack1_b", 1, b, 8'hB2);
    tick();
    cpu_rd(1, 12'h060, b); chk("ack1_c", 1, b, 8'hC3);
    tick(); chk("ack1_irq", 1, i1[1], 1'b0);

    // 061h write is not an ack here
    rv_acc(1, 1, 2'd0, 32'h11, r);
    tick(); tick();
    cpu_wr(1, 12'h061, 8'h00);
    tick(); tick(); chk("ack1_061", 1, i1[1], 1'b1);
    cpu_rd(1, 12'h060, b); chk("ack1_d", 1, b, 8'h11);
    tick(); chk("ack1_irq2", 1, i1[1], 1'b0);

    // aux channel disabled
    rv_acc(1, 1, 2'd1, 32'h08, r);
    tick(); tick(); tick();
    chk("noaux_irq12", 1, i12[1], 1'b0);
    rv_acc(1, 0, 2'd2, 0, r); chk("noaux_stat", 1, r, 32'h0);
    cpu_rd(1, 12'h064, b); chk("noaux_st64", 1, b, 8'h00);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
